// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with a valid/ready input handshake and a
// one-cycle out_valid strobe. Single-cycle ops: AND, OR, ADD, SLTU, XOR, SUB,
// SLT, SLL, SRL, SRA. Unsupported codes give result 0 and raise illegal.
// Optional feature macro: ALU_MUL_EN. When it is defined, code 1100 runs an
// iterative shift-add multiplier that takes WIDTH+1 cycles, and in_ready drops
// while it runs. When it is not defined, 1100 is an illegal code and in_ready
// is tied high.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             illegal
);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] op_res_s;
   logic             op_ill_s;
   logic [SHW-1:0]   shamt_s;
   logic             accept_s;

   assign shamt_s  = inp2[SHW-1:0];
   assign accept_s = in_valid & in_ready;

`ifdef ALU_MUL_EN
   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] mul_sum_s;

   // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
   assign mul_sum_s = acc_q + (mul_a_q[0] ? mul_b_q : ZERO_W);
   assign in_ready  = (state_q == S_IDLE);
`else
   assign in_ready  = 1'b1;
`endif

   // Decode the op code and compute every single-cycle result from the live operands.
   always_comb begin
      op_res_s = ZERO_W;
      op_ill_s = 1'b0;
      case (alu_ctrl)
         4'b0000: op_res_s = inp1 & inp2;
         4'b0001: op_res_s = inp1 | inp2;
         4'b0010: op_res_s = inp1 + inp2;
         4'b0011: op_res_s = {{(WIDTH-1){1'b0}}, (inp1 < inp2)};
         4'b0100: op_res_s = inp1 ^ inp2;
         4'b0110: op_res_s = inp1 - inp2;
         4'b0111: op_res_s = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
         4'b1000: op_res_s = inp1 << shamt_s;
         4'b1001: op_res_s = inp1 >> shamt_s;
         4'b1010: op_res_s = $unsigned($signed(inp1) >>> shamt_s);
`ifdef ALU_MUL_EN
         4'b1100: op_res_s = ZERO_W;
`endif
         default: op_ill_s = 1'b1;
      endcase
   end

   // Next-state and output logic: result registers hold unless a result is produced.
   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
      state_d = state_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s && (alu_ctrl == 4'b1100)) begin
               state_d = S_MUL;
               mul_a_d = inp1;
               mul_b_d = inp2;
               acc_d   = ZERO_W;
               cnt_d   = SHW'(WIDTH - 1);
            end else if (accept_s) begin
               result_d    = op_res_s;
               zero_d      = (op_res_s == ZERO_W);
               illegal_d   = op_ill_s;
               out_valid_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            acc_d   = mul_sum_s;
            mul_a_d = mul_a_q >> 1;
            mul_b_d = mul_b_q << 1;
            if (cnt_q == {SHW{1'b0}}) begin
               result_d    = mul_sum_s;
               zero_d      = (mul_sum_s == ZERO_W);
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = S_IDLE;
      endcase
`else
      if (accept_s) begin
         result_d    = op_res_s;
         zero_d      = (op_res_s == ZERO_W);
         illegal_d   = op_ill_s;
         out_valid_d = 1'b1;
      end else begin
         out_valid_d = 1'b0;
      end
`endif
   end

   // Result and strobe registers; reset leaves a zero result with zero asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q    <= ZERO_W;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef ALU_MUL_EN
   // Multiplier FSM state and datapath registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mul_a_q <= ZERO_W;
         mul_b_q <= ZERO_W;
         acc_q   <= ZERO_W;
         cnt_q   <= {SHW{1'b0}};
      end else begin
         state_q <= state_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end
`endif

   assign alu_result = result_q;
   assign zero       = zero_q;
   assign illegal    = illegal_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32). Uses a table of hand-computed
// vectors, hand-written handshake/reset sequences, and randomized ops checked
// against an arithmetic reference model. Follows ALU_MUL_EN like the design.
module tb_alu_seq;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_ctrl;
   logic [W-1:0]  inp1, inp2;
   logic          out_valid;
   logic [W-1:0]  alu_result;
   logic          zero;
   logic          illegal;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] last_res;
   logic         last_ill;

   typedef struct {
      logic [3:0]   ctrl;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ill;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .inp1(inp1), .inp2(inp2), .out_valid(out_valid),
      .alu_result(alu_result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic bit mul_on();
`ifdef ALU_MUL_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Reference model from the op definitions, using wide integer arithmetic.
   function automatic void ref_op(input logic [3:0] c, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic ill);
      int unsigned sh   = b % W;
      longint      sa   = longint'($signed(a));
      longint      sb   = longint'($signed(b));
      longint      pw   = longint'(64'd1) << sh;
      longint      q;
      logic [63:0] prod = 64'(a) * 64'(b);
      r   = '0;
      ill = 1'b0;
      case (c)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = W'(64'(a) + 64'(b));
         4'd3:  r = (a < b) ? 32'd1 : 32'd0;
         4'd4:  r = a ^ b;
         4'd6:  r = W'(64'(a) - 64'(b));
         4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:  r = W'(64'(a) * 64'(pw));
         4'd9:  r = a / W'(pw);
         4'd10: begin
            q = (sa >= 0) ? (sa / pw) : -((-sa + pw - 1) / pw);
            r = W'(q);
         end
         4'd12: begin
            if (mul_on()) r = prod[W-1:0];
            else ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
   endfunction

   // Issue one op, wait for its result (bounded), compare with the expectation.
   task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ei, input bit noise);
      int cyc = 0;
      bit busy_bad = 1'b0;
      @(negedge clk);
      alu_ctrl = c; inp1 = a; inp2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (mul_on() && c == 4'b1100) begin
         chk("mul_ready_low", in_ready, 1'b0);
         chk("mul_no_early_valid", out_valid, 1'b0);
         for (int n = 1; n <= W + 8; n++) begin
            @(negedge clk);
            if (noise) begin
               in_valid = 1'b1; alu_ctrl = 4'b0010; inp1 = $urandom; inp2 = $urandom;
            end
            @(posedge clk); #1;
            if (out_valid) begin
               cyc = n;
               break;
            end
            if (in_ready) busy_bad = 1'b1;
         end
         in_valid = 1'b0;
         chk("mul_latency", cyc, W);
         chk("mul_busy_ready", busy_bad, 1'b0);
         chk("mul_ready_back", in_ready, 1'b1);
      end else begin
         chk("op_valid", out_valid, 1'b1);
      end
      chk("result", alu_result, er);
      chk("zero", zero, (er == '0));
      chk("illegal", illegal, ei);
      last_res = er;
      last_ill = ei;
   endtask

   // One idle cycle: no strobe, outputs hold.
   task automatic idle_chk();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_no_valid", out_valid, 1'b0);
      chk("idle_hold", alu_result, last_res);
      chk("idle_hold_ill", illegal, last_ill);
   endtask

   task automatic reset_chk(input string nm);
      chk({nm, "_ready"}, in_ready, 1'b1);
      chk({nm, "_valid"}, out_valid, 1'b0);
      chk({nm, "_res"}, alu_result, '0);
      chk({nm, "_zero"}, zero, 1'b1);
      chk({nm, "_ill"}, illegal, 1'b0);
   endtask

   initial begin
      logic [W-1:0] er;
      logic         ei;
      logic [3:0]   codes [12];
      int           pulses;

      codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd15};
      rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'd0; inp1 = '0; inp2 = '0;
      last_res = '0; last_ill = 1'b0;

      vecs.push_back('{4'b0010, 32'd7,        32'd5,        32'd12,       1'b0});
      vecs.push_back('{4'b0110, 32'd5,        32'd5,        32'd0,        1'b0});
      vecs.push_back('{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0});
      vecs.push_back('{4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0});
      vecs.push_back('{4'b0100, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0});
      vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0});
      vecs.push_back('{4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0});
      vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0});
      vecs.push_back('{4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0});
      vecs.push_back('{4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0});
      vecs.push_back('{4'b0011, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0});
      vecs.push_back('{4'b1000, 32'd1,        32'd33,       32'd2,        1'b0});
      vecs.push_back('{4'b1001, 32'h80000000, 32'd31,       32'd1,        1'b0});
      vecs.push_back('{4'b1010, 32'h80000000, 32'd4,        32'hF8000000, 1'b0});
      vecs.push_back('{4'b1010, 32'h40000000, 32'd36,       32'h04000000, 1'b0});
      vecs.push_back('{4'b1111, 32'd9,        32'd9,        32'd0,        1'b1});
      vecs.push_back('{4'b0101, 32'd9,        32'd9,        32'd0,        1'b1});
`ifdef ALU_MUL_EN
      vecs.push_back('{4'b1100, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{4'b1100, 32'h00000007, 32'h00000006, 32'd42,       1'b0});
`else
      vecs.push_back('{4'b1100, 32'h0000FFFF, 32'h00010001, 32'd0,        1'b1});
`endif

      #2;
      reset_chk("por");
      @(negedge clk); rst = 1'b0;

      // Table-driven vectors.
      foreach (vecs[i]) begin
         do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, 1'b0);
      end
      idle_chk();

      // Back-to-back accepts on three consecutive edges.
      @(negedge clk); in_valid = 1'b1; alu_ctrl = 4'b0010; inp1 = 32'd7; inp2 = 32'd5;
      @(posedge clk); #1;
      chk("b2b_v1", out_valid, 1'b1); chk("b2b_r1", alu_result, 32'd12);
      @(negedge clk); alu_ctrl = 4'b0110; inp1 = 32'd5; inp2 = 32'd5;
      @(posedge clk); #1;
      chk("b2b_v2", out_valid, 1'b1); chk("b2b_r2", alu_result, 32'd0); chk("b2b_z2", zero, 1'b1);
      @(negedge clk); alu_ctrl = 4'b1010; inp1 = 32'h80000000; inp2 = 32'd4;
      @(posedge clk); #1;
      chk("b2b_v3", out_valid, 1'b1); chk("b2b_r3", alu_result, 32'hF8000000);
      chk("b2b_z3", zero, 1'b0);
      last_res = 32'hF8000000; last_ill = 1'b0;
      idle_chk();

      // Asynchronous reset in the middle of a cycle.
      do_op(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
      @(negedge clk); #2; rst = 1'b1; #1;
      reset_chk("mid_rst");
      @(negedge clk); rst = 1'b0;
      last_res = '0; last_ill = 1'b0;

`ifdef ALU_MUL_EN
      // MUL with in_valid held high while busy: extra request must be ignored.
      do_op(4'b1100, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b1);
      idle_chk();

      // Reset at iteration 10 of a multiply: no result strobe afterwards.
      @(negedge clk); in_valid = 1'b1; alu_ctrl = 4'b1100; inp1 = 32'd3; inp2 = 32'd5;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2; rst = 1'b1; #1;
      reset_chk("mul_rst");
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < W + 4; n++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      chk("mul_rst_no_valid", pulses, 0);
      last_res = '0; last_ill = 1'b0;
      do_op(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
`endif

      // Randomized ops against the reference model.
      for (int i = 0; i < 120; i++) begin
         logic [3:0]   c;
         logic [W-1:0] a, b;
         c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 11)];
         a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         b = ($urandom_range(0, 5) == 0) ? a : $urandom;
         ref_op(c, a, b, er, ei);
         do_op(c, a, b, er, ei, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_chk();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end
endmodule
